// File: rtl/vend_pkg.sv
// Shared coin codes, price and FSM state encoding for the vending session arbiter.
package vend_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        RS5     = 2'b01,
        RS10    = 2'b10,
        ILLEGAL = 2'b11
    } coin_e;

    localparam int PRICE = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SESSION = 2'b01,
        DONE    = 2'b10,
        REFUND  = 2'b11
    } state_e;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        logic [4:0] value;
        value = 5'd0;
        if (code == RS5)  value = 5'd5;
        if (code == RS10) value = 5'd10;
        return value;
    endfunction

    // Rupee credit back to the coin code that the kiosk refund path understands.
    function automatic logic [1:0] credit_code(input logic [4:0] credit);
        logic [1:0] code;
        code = NONE;
        if (credit == 5'd5)  code = RS5;
        if (credit == 5'd10) code = RS10;
        return code;
    endfunction

endpackage

// File: rtl/vend_session_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_owner, one-hot result.
module rr_picker #(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]         req,
    input  logic [$clog2(N_PORTS)-1:0] last_owner,
    output logic [N_PORTS-1:0]         winner
);

    localparam int IW = $clog2(N_PORTS);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = IW'((int'(last_owner) + k) % N_PORTS);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one vending core between N_PORTS coin kiosks: round-robin sessions,
// coin forwarding from the owner only, idle timeout with credit refund.
module vend_session_arbiter
    import vend_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           req,
    input  logic [2*N_PORTS-1:0]         coin_in,
    output logic [N_PORTS-1:0]           grant,
    output logic [1:0]                   vm_inp,
    output logic                         vm_clr,
    input  logic                         vm_out,
    input  logic [1:0]                   vm_change,
    output logic                         dispense_vld,
    output logic [$clog2(N_PORTS)-1:0]   dispense_port,
    output logic [1:0]                   change_out,
    output logic                         refund_vld,
    output logic [1:0]                   refund_amt,
    output logic                         coin_err,
    output logic [1:0]                   fsm_state
);

    localparam int IW = $clog2(N_PORTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [N_PORTS-1:0]   grant_q, grant_d, winner;
    logic [IW-1:0]        owner_q, owner_d, last_q, last_d, win_idx;
    logic [4:0]           credit_q, credit_d;
    logic [CW-1:0]        idle_q, idle_d;
    logic [1:0]           change_q, change_d;
    logic [1:0]           owner_coin;
    logic [4:0]           coin_sum;
    logic                 abandon;

    rr_picker #(.N_PORTS(N_PORTS)) u_picker (
        .req        (req),
        .last_owner (last_q),
        .winner     (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (winner[i]) win_idx = IW'(i);
        end
    end

    assign owner_coin = coin_in[{owner_q, 1'b0} +: 2];
    assign coin_sum   = credit_q + coin_value(owner_coin);
    assign abandon    = (idle_q == CW'(TIMEOUT)) || !req[owner_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            last_q   <= IW'(N_PORTS - 1);
            credit_q <= '0;
            idle_q   <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            credit_q <= credit_d;
            idle_q   <= idle_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_d        = last_q;
        credit_d      = credit_q;
        idle_d        = idle_q;
        change_d      = change_q;
        vm_inp        = NONE;
        vm_clr        = 1'b0;
        dispense_vld  = 1'b0;
        dispense_port = '0;
        refund_vld    = 1'b0;
        refund_amt    = NONE;
        coin_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d  = winner;
                    owner_d  = win_idx;
                    credit_d = '0;
                    idle_d   = '0;
                    state_d  = SESSION;
                end
            end
            SESSION: begin
                if (vm_out) begin
                    state_d  = DONE;
                    change_d = vm_change;
                    credit_d = '0;
                end else if (abandon) begin
                    if (credit_q == '0) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end else begin
                        state_d = REFUND;
                    end
                end
                // A coin arriving while the session is being abandoned is not forwarded,
                // so the refunded credit always matches what the core accumulated.
                if (!abandon || vm_out) begin
                    if (owner_coin == ILLEGAL) begin
                        coin_err = 1'b1;
                    end else begin
                        vm_inp = owner_coin;
                        if (owner_coin == NONE) begin
                            if (idle_q != CW'(TIMEOUT)) idle_d = idle_q + 1'b1;
                        end else begin
                            idle_d = '0;
                            if (!vm_out && 32'(coin_sum) < PRICE) credit_d = coin_sum;
                        end
                    end
                end
            end
            DONE: begin
                dispense_vld  = 1'b1;
                dispense_port = owner_q;
                grant_d       = '0;
                last_d        = owner_q;
                state_d       = IDLE;
            end
            REFUND: begin
                refund_vld    = 1'b1;
                refund_amt    = credit_code(credit_q);
                dispense_port = owner_q;
                vm_clr        = 1'b1;
                credit_d      = '0;
                grant_d       = '0;
                last_d        = owner_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = grant_q;
    assign change_out = change_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter: sessions, round robin, timeout refund, reset.
module tb_vend_session_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] coin_in;
    logic [3:0] grant;
    logic [1:0] vm_inp;
    logic       vm_clr;
    logic       vm_out;
    logic [1:0] vm_change;
    logic       dispense_vld;
    logic [1:0] dispense_port;
    logic [1:0] change_out;
    logic       refund_vld;
    logic [1:0] refund_amt;
    logic       coin_err;
    logic [1:0] fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    vend_session_arbiter #(.N_PORTS(4), .TIMEOUT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .coin_in       (coin_in),
        .grant         (grant),
        .vm_inp        (vm_inp),
        .vm_clr        (vm_clr),
        .vm_out        (vm_out),
        .vm_change     (vm_change),
        .dispense_vld  (dispense_vld),
        .dispense_port (dispense_port),
        .change_out    (change_out),
        .refund_vld    (refund_vld),
        .refund_amt    (refund_amt),
        .coin_err      (coin_err),
        .fsm_state     (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_vm_inp"}, 32'(vm_inp), 0);
        chk({tag, "_vm_clr"}, 32'(vm_clr), 0);
        chk({tag, "_disp"}, 32'(dispense_vld), 0);
        chk({tag, "_refund"}, 32'(refund_vld), 0);
        chk({tag, "_coin_err"}, 32'(coin_err), 0);
        chk({tag, "_change"}, 32'(change_out), 0);
        chk({tag, "_amt"}, 32'(refund_amt), 0);
        chk({tag, "_port"}, 32'(dispense_port), 0);
        chk({tag, "_state"}, 32'(fsm_state), 0);
    endtask

    initial begin
        reset = 1'b0; req = '0; coin_in = '0; vm_out = 1'b0; vm_change = '0;
        cyc(); cyc();
        chk_reset_values("reset");
        reset = 1'b1;

        // vm_out while idle is ignored
        vm_out = 1'b1;
        cyc();
        vm_out = 1'b0; #1;
        chk("idle_vm_out_disp", 32'(dispense_vld), 0);
        chk("idle_vm_out_state", 32'(fsm_state), 0);

        // single kiosk 0: Rs5 + Rs10 then dispense
        req = 4'b0001; #1;
        chk("t1_grant_reg", 32'(grant), 0);
        cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_state", 32'(fsm_state), 1);
        coin_in = 8'h01; #1;
        chk("t1_inp5", 32'(vm_inp), 1);
        cyc();
        coin_in = 8'h02; #1;
        chk("t1_inp10", 32'(vm_inp), 2);
        cyc();
        coin_in = 8'h00; vm_out = 1'b1; vm_change = 2'b00; #1;
        chk("t1_no_early_disp", 32'(dispense_vld), 0);
        cyc();
        vm_out = 1'b0; req = 4'b0000; #1;
        chk("t1_disp", 32'(dispense_vld), 1);
        chk("t1_port", 32'(dispense_port), 0);
        chk("t1_change", 32'(change_out), 0);
        chk("t1_grant_done", 32'(grant), 32'h1);
        cyc();
        chk("t1_grant_drop", 32'(grant), 0);
        chk("t1_disp_pulse", 32'(dispense_vld), 0);

        // reset restores last_owner so rotation starts at port 0
        reset = 1'b0; #1;
        cyc();
        reset = 1'b1;

        req = 4'b1111; #1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_grant", 32'(grant), 32'(1) << k);
            vm_out = 1'b1; vm_change = 2'(k); #1;
            cyc();
            vm_out = 1'b0; #1;
            chk("rr_disp", 32'(dispense_vld), 1);
            chk("rr_port", 32'(dispense_port), 32'(k));
            chk("rr_change", 32'(change_out), 32'(k));
            cyc();
            chk("rr_gap_grant", 32'(grant), 0);
        end
        req = 4'b0000;

        // kiosk 1: Rs10 then idles until the timeout refund
        req = 4'b0010; #1;
        cyc();
        chk("t3_grant", 32'(grant), 32'h2);
        coin_in = 8'b0000_1000; #1;
        chk("t3_inp", 32'(vm_inp), 2);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            coin_in = 8'h00; #1;
            chk("t3_wait_refund", 32'(refund_vld), 0);
            chk("t3_wait_state", 32'(fsm_state), 1);
        end
        cyc();
        req = 4'b0000; #1;
        chk("t3_refund", 32'(refund_vld), 1);
        chk("t3_amt", 32'(refund_amt), 2);
        chk("t3_clr", 32'(vm_clr), 1);
        chk("t3_port", 32'(dispense_port), 1);
        cyc();
        chk("t3_clr_once", 32'(vm_clr), 0);
        chk("t3_refund_once", 32'(refund_vld), 0);
        chk("t3_grant_drop", 32'(grant), 0);

        // kiosk 0 owner while kiosk 2 drops Rs10 coins
        req = 4'b0001; #1;
        cyc();
        chk("t4_grant", 32'(grant), 32'h1);
        coin_in = 8'b0010_0001; #1;
        chk("t4_inp_owner", 32'(vm_inp), 1);
        cyc();
        coin_in = 8'b0010_0000; #1;
        chk("t4_inp_blocked", 32'(vm_inp), 0);
        cyc();
        coin_in = 8'h00; req = 4'b0000; #1;
        cyc();
        chk("t4_refund", 32'(refund_vld), 1);
        chk("t4_amt", 32'(refund_amt), 1);
        chk("t4_port", 32'(dispense_port), 0);
        cyc();
        chk("t4_state", 32'(fsm_state), 0);

        // kiosk 2 presents illegal coins around one Rs5
        req = 4'b0100; #1;
        cyc();
        chk("t5_grant", 32'(grant), 32'h4);
        coin_in = 8'b0011_0000; #1;
        chk("t5_err", 32'(coin_err), 1);
        chk("t5_err_inp", 32'(vm_inp), 0);
        cyc();
        coin_in = 8'b0001_0000; #1;
        chk("t5_err_clear", 32'(coin_err), 0);
        chk("t5_inp5", 32'(vm_inp), 1);
        cyc();
        coin_in = 8'b0011_0000; #1;
        chk("t5_err2", 32'(coin_err), 1);
        cyc();
        coin_in = 8'h00; req = 4'b0000; #1;
        cyc();
        chk("t5_amt", 32'(refund_amt), 1);
        cyc();

        // kiosk 3 session cut by reset: credit discarded, no refund
        req = 4'b1000; #1;
        cyc();
        chk("t6_grant", 32'(grant), 32'h8);
        coin_in = 8'b1000_0000; #1;
        cyc();
        coin_in = 8'h00; reset = 1'b0; #1;
        chk_reset_values("midrst");
        req = 4'b0000;
        cyc();
        reset = 1'b1; #1;
        cyc();
        chk("t6_no_refund", 32'(refund_vld), 0);
        chk("t6_no_clr", 32'(vm_clr), 0);

        // vm_out and req drop in the same cycle: dispense wins
        req = 4'b0001; #1;
        cyc();
        chk("t7_grant", 32'(grant), 32'h1);
        coin_in = 8'h01; #1;
        cyc();
        coin_in = 8'h00; req = 4'b0000; vm_out = 1'b1; #1;
        cyc();
        vm_out = 1'b0; #1;
        chk("t7_disp", 32'(dispense_vld), 1);
        chk("t7_no_refund", 32'(refund_vld), 0);
        chk("t7_state", 32'(fsm_state), 2);
        cyc();
        chk("t7_idle", 32'(fsm_state), 0);
        chk("t7_grant_drop", 32'(grant), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
